// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared FSM state type and SCCB constants for the OV7670 register loader.
package ov7670_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DONE} state_t;
  localparam logic [15:0] SCCB_END_MARKER = 16'hFFFF;
  localparam logic [7:0] COM7_ADDR = 8'h12;
endpackage

// File: rtl/ov7670_sccb_config_if.sv
// ov7670_sccb_config_if: start/status handshake plus the SCCB pin pair of the camera loader.
interface ov7670_sccb_config_if;
  logic start;
  logic sioc;
  logic siod_oe;
  logic busy;
  logic done;
  logic [7:0] reg_idx;
  modport master (output start, input sioc, siod_oe, busy, done, reg_idx);
  modport slave (input start, output sioc, siod_oe, busy, done, reg_idx);
endinterface

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: combinational camera register table, {addr,data} per index, end-marker terminated.
module ov7670_reg_rom
  import ov7670_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [15:0] entry
);
  always_comb entry = idx == 8'd0 ? 16'h1280 :
                      idx == 8'd1 ? 16'h1101 :
                      idx == 8'd2 ? 16'h8C00 : SCCB_END_MARKER;
endmodule

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks the register table and writes each entry over SCCB (3-phase write).
// Optional OV7670_SOFTRST_WAIT_EN stretches the gap after a COM7 soft reset to at least 1 ms.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int         CLK_HZ   = 25_000_000,
  parameter int         SCCB_HZ  = 100_000,
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter int         GAP_CYC  = 1000
) (
  input logic clk,
  input logic rst,
  ov7670_sccb_config_if.slave bus
);
  localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int GAP_LONG = GAP_CYC > CLK_HZ / 1000 ? GAP_CYC : CLK_HZ / 1000;
  localparam logic [31:0] Q_LAST = 32'(QDIV - 1);
  localparam logic [31:0] G_SHORT = 32'(GAP_CYC - 1);
  localparam logic [31:0] G_LONG = 32'(GAP_LONG - 1);
  state_t state_q, state_d;
  logic [31:0] qcnt_q, qcnt_d, gcnt_q, gcnt_d;
  logic [1:0] qph_q, qph_d;
  logic [4:0] slot_q, slot_d;
  logic [26:0] sh_q, sh_d;
  logic [7:0] idx_q, idx_d;
  logic long_q, long_d;
  logic [15:0] entry;
  logic run, tick, phase_end, sioc, siod;
  ov7670_reg_rom u_rom (.idx(idx_q), .entry(entry));
  always_comb begin
    state_d = state_q;
    qcnt_d = qcnt_q;
    gcnt_d = gcnt_q;
    qph_d = qph_q;
    slot_d = slot_q;
    sh_d = sh_q;
    idx_d = idx_q;
    long_d = long_q;
    run = state_q inside {S_START, S_BITS, S_STOP};
    tick = run && qcnt_q == Q_LAST;
    phase_end = tick && qph_q == 2'd3;
    if (run) qcnt_d = tick ? '0 : qcnt_q + 32'd1;
    if (tick) qph_d = qph_q + 2'd1;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) begin
        state_d = S_LOAD;
        idx_d = '0;
      end
      S_LOAD: begin
        qcnt_d = '0;
        qph_d = '0;
        slot_d = '0;
        // 9th slot of every byte is pre-loaded as 1 so the shifter releases SIOD there
        sh_d = {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
`ifdef OV7670_SOFTRST_WAIT_EN
        long_d = entry[15:8] == COM7_ADDR && entry[7];
`else
        long_d = 1'b0;
`endif
        state_d = (entry == SCCB_END_MARKER || idx_q == 8'hFF) ? S_DONE : S_START;
      end
      S_START: if (phase_end) state_d = S_BITS;
      S_BITS: if (phase_end) begin
        sh_d = {sh_q[25:0], 1'b1};
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd26) state_d = S_STOP;
      end
      S_STOP: if (phase_end) begin
        state_d = S_GAP;
        gcnt_d = '0;
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 32'd1;
        if (gcnt_q == (long_q ? G_LONG : G_SHORT)) begin
          idx_d = idx_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q <= '0;
      gcnt_q <= '0;
      qph_q <= '0;
      slot_q <= '0;
      sh_q <= '1;
      idx_q <= '0;
      long_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q <= qcnt_d;
      gcnt_q <= gcnt_d;
      qph_q <= qph_d;
      slot_q <= slot_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      long_q <= long_d;
    end
  end
  // Pins decode straight from registered state so an async reset releases the bus at once
  always_comb begin
    sioc = state_q == S_START ? qph_q != 2'd3 :
           state_q == S_BITS  ? qph_q[1] :
           state_q == S_STOP  ? qph_q != 2'd0 : 1'b1;
    siod = state_q == S_START ? qph_q == 2'd0 :
           state_q == S_BITS  ? sh_q[26] :
           state_q == S_STOP  ? qph_q == 2'd3 : 1'b1;
  end
  assign bus.sioc = sioc;
  assign bus.siod_oe = ~siod;
  assign bus.busy = !(state_q inside {S_IDLE, S_DONE});
  assign bus.done = state_q == S_DONE;
  assign bus.reg_idx = idx_q;
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: per-cycle waveform model, SCCB byte decoder and protocol monitor.
module tb_ov7670_sccb_config;
  localparam int CLK_HZ = 1_600_000;
  localparam int SCCB_HZ = 100_000;
  localparam int GAP_CYC = 8;
  localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int GAP_LONG = GAP_CYC > CLK_HZ / 1000 ? GAP_CYC : CLK_HZ / 1000;
`ifdef OV7670_SOFTRST_WAIT_EN
  localparam bit SOFT = 1'b1;
  int exp_gap[2] = '{1600, 8};
`else
  localparam bit SOFT = 1'b0;
  int exp_gap[2] = '{8, 8};
`endif
  typedef struct packed {logic sioc; logic oe; logic busy; logic done; logic [7:0] idx;} obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ov7670_sccb_config_if bus();
  ov7670_sccb_config #(.CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ADDR(8'h42), .GAP_CYC(GAP_CYC))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t exp_q[$];
  bit model_on = 1'b0;
  logic [7:0] byte_q[$];
  int gap_q[$];
  logic [15:0] table_e[3] = '{16'h1280, 16'h1101, 16'h8C00};
  logic [7:0] exp_bytes[9] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01, 8'h42, 8'h8C, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_len(input logic [15:0] e);
    return (SOFT && e[15:8] == 8'h12 && e[7]) ? GAP_LONG : GAP_CYC;
  endfunction

  function automatic void push(input logic sioc, input logic siod, input logic [7:0] idx, input int n);
    obs_t o;
    o = {sioc, ~siod, 1'b1, 1'b0, idx};
    repeat (n) exp_q.push_back(o);
  endfunction

  // Expected pin/status trace for a whole table run, one element per clock
  function automatic void build_model();
    logic [26:0] fr;
    exp_q.delete();
    push(1, 1, 8'd0, 1);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ix;
      ix = 8'(i);
      fr = {8'h42, 1'b1, table_e[i][15:8], 1'b1, table_e[i][7:0], 1'b1};
      push(1, 1, ix, QDIV); push(1, 0, ix, QDIV); push(1, 0, ix, QDIV); push(0, 0, ix, QDIV);
      for (int k = 26; k >= 0; k--) begin
        push(0, fr[k], ix, 2 * QDIV);
        push(1, fr[k], ix, 2 * QDIV);
      end
      push(0, 0, ix, QDIV); push(1, 0, ix, QDIV); push(1, 0, ix, QDIV); push(1, 1, ix, QDIV);
      push(1, 1, ix, gap_len(table_e[i]));
      push(1, 1, ix + 8'd1, 1);
    end
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 8'd3});
  endfunction

  always @(posedge clk) begin
    #1;
    if (model_on && exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.reg_idx};
      chk("model", 32'(a), 32'(e));
    end
  end

  logic p_sioc = 1'b1;
  logic p_siod = 1'b1;
  logic m_siod;
  bit act = 1'b0;
  int bits = 0;
  int stop_t = -1;
  int cyc = 0;
  logic [8:0] sr = '0;
  always @(posedge clk) begin
    #1;
    cyc++;
    m_siod = ~bus.siod_oe;
    if (rst) begin
      act = 1'b0;
      bits = 0;
      stop_t = -1;
    end else if (p_sioc && bus.sioc && m_siod !== p_siod) begin
      chk("proto_edge", 32'((!m_siod && !act) || (m_siod && act && bits == 27)), 32'd1);
      if (!m_siod) begin
        if (stop_t >= 0 && bus.reg_idx != 8'd0) gap_q.push_back(cyc - stop_t - 1 - 2 * QDIV);
        act = 1'b1;
        bits = 0;
      end else begin
        act = 1'b0;
        stop_t = cyc;
      end
    end else if (!p_sioc && bus.sioc && act && bits < 27) begin
      sr = {sr[7:0], m_siod};
      bits++;
      if (bits % 9 == 0) byte_q.push_back(sr[8:1]);
    end
    p_sioc = bus.sioc;
    p_siod = m_siod;
  end

  task automatic run_seq(input bit inj);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    byte_q.delete();
    gap_q.delete();
    build_model();
    @(negedge clk);
    bus.start = 1'b1;
    model_on = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 20000 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      bus.start = inj && exp_q.size() > 3 && $urandom_range(0, 99) < 5;
    end
    bus.start = 1'b0;
    chk("drain", 32'(exp_q.size()), 32'd0);
    model_on = 1'b0;
    @(negedge clk);
    chk("end_status", 32'({bus.busy, bus.done, bus.reg_idx}), 32'({1'b0, 1'b1, 8'd3}));
    chk("byte_count", 32'(byte_q.size()), 32'd9);
    for (int k = 0; k < 9 && k < byte_q.size(); k++) chk("byte", 32'(byte_q[k]), 32'(exp_bytes[k]));
    chk("gap_count", 32'(gap_q.size()), 32'd2);
    for (int k = 0; k < 2 && k < gap_q.size(); k++) chk("gap_len", 32'(gap_q[k]), 32'(exp_gap[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.reg_idx}), 32'h800);
    end
    run_seq(1'b0);
    run_seq(1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 5000 && bus.reg_idx != 8'd1; c++) @(negedge clk);
    chk("reach_idx1", 32'(bus.reg_idx), 32'd1);
    repeat ($urandom_range(20, 400)) @(negedge clk);
    chk("busy_mid", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.reg_idx}), 32'h800);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_seq(1'b1);
    run_seq(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
